// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: per-digit prescaler, digit position counter and a
// once-per-frame sequential double-dabble BCD conversion. Optional: LEADING_ZERO_BLANK_EN.
module fnd_scan_controller #(
  parameter int TICK_DIV = 100000,
  parameter int VALUE_W  = 14
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [VALUE_W-1:0] i_value,
  output logic [1:0]         o_digitPosition,
  output logic [3:0]         o_bcd,
  output logic               o_blank,
  output logic               o_overflow,
  output logic               o_frameDone
);

  localparam int                 CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [VALUE_W-1:0] VAL_MAX   = VALUE_W'(9999);
  localparam logic [3:0]         ITER_LAST = 4'(VALUE_W - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SHIFT,
    S_UPDATE,
    S_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           pos_q, pos_d;
  logic [VALUE_W-1:0]   bin_q, bin_d;
  logic [15:0]          bcd_q, bcd_d;
  logic [3:0]           iter_q, iter_d;
  logic                 ovf_cap_q, ovf_cap_d;
  logic [15:0]          disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 frame_wrap;
  logic [15+VALUE_W:0]  dd_shift;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Prescaler and digit position
  always_comb begin
    tick       = i_enable && (cnt_q == CNT_MAX);
    frame_wrap = tick && (pos_q == 2'd3);
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    if (tick) begin
      cnt_d = '0;
      pos_d = pos_q + 2'd1;
    end else if (i_enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Conversion FSM
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    ovf_cap_d = ovf_cap_q;
    disp_d    = disp_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    dd_shift  = {add3(bcd_q), bin_q} << 1;
    unique case (state_q)
      S_LOAD: begin
        bin_d     = (i_value > VAL_MAX) ? VAL_MAX : i_value;
        ovf_cap_d = (i_value > VAL_MAX);
        bcd_d     = '0;
        iter_d    = '0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = dd_shift;
        iter_d         = iter_q + 4'd1;
        if (iter_q == ITER_LAST) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // frameDone is registered so its pulse coincides with the new digits appearing.
        disp_d  = bcd_q;
        ovf_d   = ovf_cap_q;
        done_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (frame_wrap) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      pos_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      iter_q    <= '0;
      ovf_cap_q <= 1'b0;
      disp_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      iter_q    <= iter_d;
      ovf_cap_q <= ovf_cap_d;
      disp_q    <= disp_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    unique case (pos_q)
      2'd0:    o_bcd = disp_q[3:0];
      2'd1:    o_bcd = disp_q[7:4];
      2'd2:    o_bcd = disp_q[11:8];
      default: o_bcd = disp_q[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    unique case (pos_q)
      2'd3:    o_blank = (disp_q[15:12] == 4'd0);
      2'd2:    o_blank = (disp_q[15:8] == 8'd0);
      2'd1:    o_blank = (disp_q[15:4] == 12'd0);
      default: o_blank = 1'b0;
    endcase
  end
`else
  assign o_blank = 1'b0;
`endif

  assign o_digitPosition = pos_q;
  assign o_overflow      = ovf_q;
  assign o_frameDone     = done_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with TICK_DIV=32; blank checks follow LEADING_ZERO_BLANK_EN.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [13:0] val = 14'd1234;
  logic [1:0]  pos;
  logic [3:0]  bcd;
  logic        blank, ovf, done;
  int          checks = 0;
  int          passed = 0;
  int          shown  = 0;

  fnd_scan_controller #(.TICK_DIV(32), .VALUE_W(14)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_value        (val),
    .o_digitPosition(pos),
    .o_bcd          (bcd),
    .o_blank        (blank),
    .o_overflow     (ovf),
    .o_frameDone    (done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_blank(input int v, input int p);
    int r;
    r = 0;
`ifdef LEADING_ZERO_BLANK_EN
    case (p)
      3: r = (v / 1000 == 0) ? 1 : 0;
      2: r = (v / 100 == 0) ? 1 : 0;
      1: r = (v / 10 == 0) ? 1 : 0;
      default: r = 0;
    endcase
`endif
    return r;
  endfunction

  // shown = value the display registers should currently hold
  task automatic chk_slot(input string tag, input int p, input int d);
    chk({tag, ".pos"}, int'(pos), p);
    chk({tag, ".bcd"}, int'(bcd), d);
    chk({tag, ".blank"}, int'(blank), exp_blank(shown, p));
  endtask

  initial begin
    // Reset state
    step(3);
    chk_slot("rst", 0, 0);
    chk("rst.ovf", int'(ovf), 0);
    chk("rst.done", int'(done), 0);
    rst = 1'b0;                 // edge count k below = edges since release

    // Test 1: first conversion
    step(15);                   // k=15
    chk("t1.done_early", int'(done), 0);
    chk("t1.bcd_early", int'(bcd), 0);
    step(1);                    // k=16
    shown = 1234;
    chk("t1.done", int'(done), 1);
    chk_slot("t1.p0", 0, 4);
    chk("t1.ovf", int'(ovf), 0);
    step(1);                    // k=17
    chk("t1.done_pulse", int'(done), 0);

    // Test 2: position stepping
    step(14);                   // k=31
    chk("t2.pre_tick", int'(pos), 0);
    step(1);                    // k=32
    chk_slot("t2.p1", 1, 3);
    step(32);                   // k=64
    chk_slot("t2.p2", 2, 2);
    step(32);                   // k=96
    chk_slot("t2.p3", 3, 1);

    // Test 3: saturation then small value
    val = 14'd12000;
    step(32);                   // k=128 frameWrap
    chk_slot("t3.wrap", 0, 4);
    step(15);                   // k=143
    chk("t3.old_bcd", int'(bcd), 4);
    step(1);                    // k=144
    shown = 9999;
    chk("t3.done", int'(done), 1);
    chk_slot("t3.p0", 0, 9);
    chk("t3.ovf", int'(ovf), 1);
    step(16);
    chk_slot("t3.p1", 1, 9);
    step(32);
    chk_slot("t3.p2", 2, 9);
    step(32);                   // k=224
    chk_slot("t3.p3", 3, 9);
    val = 14'd42;
    step(48);                   // k=272
    shown = 42;
    chk_slot("t3b.p0", 0, 2);
    chk("t3b.ovf", int'(ovf), 0);
    step(16);
    chk_slot("t3b.p1", 1, 4);
    step(32);
    chk_slot("t3b.p2", 2, 0);
    step(32);                   // k=352
    chk_slot("t3b.p3", 3, 0);

    // Test 4: value change mid-frame
    val = 14'd1234;
    step(48);                   // k=400
    shown = 1234;
    chk_slot("t4.p0", 0, 4);
    step(16);                   // k=416
    chk_slot("t4.p1", 1, 3);
    val = 14'd5678;
    step(32);
    chk_slot("t4.p2", 2, 2);
    step(32);
    chk_slot("t4.p3", 3, 1);
    step(47);                   // k=527
    chk("t4.old_bcd", int'(bcd), 4);
    step(1);                    // k=528
    shown = 5678;
    chk_slot("t4.new_p0", 0, 8);
    step(16);
    chk_slot("t4.new_p1", 1, 7);
    step(32);                   // k=576, prescaler count 0
    chk_slot("t4.new_p2", 2, 6);

    // Test 5: enable hold, then reset mid-conversion
    step(10);                   // count 10
    en = 1'b0;
    step(100);
    chk_slot("t5.hold", 2, 6);
    en = 1'b1;
    step(21);                   // count reaches 31
    chk("t5.remain", int'(pos), 2);
    step(1);
    chk_slot("t5.resume", 3, 5);
    step(32);                   // frameWrap, snapshot in progress
    chk("t5.wrap", int'(pos), 0);
    step(5);                    // mid-SHIFT
    rst = 1'b1;
    #1;
    shown = 0;
    chk_slot("t5.rst", 0, 0);
    chk("t5.rst_done", int'(done), 0);
    val = 14'd7;
    step(2);
    rst = 1'b0;
    step(15);
    chk("t5.done_early", int'(done), 0);
    step(1);                    // k=16
    shown = 7;
    chk("t5.done", int'(done), 1);

    // Test 6: leading-zero blanking
    chk_slot("t6a.p0", 0, 7);
    step(16);
    chk_slot("t6a.p1", 1, 0);
    step(32);
    chk_slot("t6a.p2", 2, 0);
    step(32);                   // k=96
    chk_slot("t6a.p3", 3, 0);
    val = 14'd0;
    step(48);                   // k=144
    shown = 0;
    chk_slot("t6b.p0", 0, 0);
    step(16);
    chk_slot("t6b.p1", 1, 0);
    step(32);
    chk_slot("t6b.p2", 2, 0);
    step(32);                   // k=224
    chk_slot("t6b.p3", 3, 0);
    val = 14'd1005;
    step(48);                   // k=272
    shown = 1005;
    chk_slot("t6c.p0", 0, 5);
    step(16);
    chk_slot("t6c.p1", 1, 0);
    step(32);
    chk_slot("t6c.p2", 2, 0);
    step(32);
    chk_slot("t6c.p3", 3, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
